// File: rtl/ibex_icache_sram_responder.sv
// Behavioural SRAM responder for one icache tag/data way.
// Services masked writes, returns read data one cycle after a read request,
// and can corrupt returned data on demand so the icache ECC paths can be
// exercised deterministically.
module ibex_icache_sram_responder #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 write_i,
  input  logic [31:0]          addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [DataWidth-1:0] wmask_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 rvalid_o,
  input  logic                 inj_req_i,
  input  logic [1:0]           inj_mode_i,
  input  logic [7:0]           inj_bit0_i,
  input  logic [7:0]           inj_bit1_i,
  output logic                 inj_ack_o,
  output logic                 inj_err_o,
  output logic                 inj_armed_o,
  output logic [15:0]          inj_count_o
);

  localparam int unsigned IdxW     = $clog2(Depth);
  localparam logic [8:0]  WidthLim = 9'(DataWidth);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED_ONE = 2'd1,
    ARMED_TWO = 2'd2,
    PERSIST   = 2'd3
  } inj_state_e;

  logic [DataWidth-1:0] mem [Depth];
  logic [IdxW-1:0]      idx;
  logic                 rd_fire;
  logic                 inj_bad;
  logic [DataWidth-1:0] flip_mask;
  inj_state_e           state;
  logic [7:0]           bit0_q;
  logic [7:0]           bit1_q;

  // Upper address bits are deliberately ignored (index wraps modulo Depth).
  logic unused_addr;
  assign unused_addr = ^addr_i[31:IdxW];

  assign idx     = addr_i[IdxW-1:0];
  // A read only fires when the strobe is known high; X strobes fail the
  // if-tests below and therefore never consume an armed injection.
  assign rd_fire = req_i & ~write_i;

  // Reject out-of-range bit indices, and identical indices for a double flip.
  assign inj_bad = ({1'b0, inj_bit0_i} >= WidthLim) ||
                   ((inj_mode_i == 2'd1) &&
                    (({1'b0, inj_bit1_i} >= WidthLim) || (inj_bit1_i == inj_bit0_i)));

  // Flip mask derived from the current (pre-update) injection state.
  always_comb begin
    // NOTE: every bit gets a value on every path, so no latch is inferred.
    flip_mask = '0;
    for (int b = 0; b < DataWidth; b++) begin
      flip_mask[b] = ((state != IDLE) && (8'(b) == bit0_q)) ||
                     ((state == ARMED_TWO) && (8'(b) == bit1_q));
    end
  end

  // Storage array: bitwise-masked writes.
  // NOTE: the array has no reset; contents survive rst_ni and unwritten words read X.
  always_ff @(posedge clk_i) begin
    if (req_i && write_i) begin
      mem[idx] <= (mem[idx] & ~wmask_i) | (wdata_i & wmask_i);
    end
  end

  // Read port: one-cycle latency, data held between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= rd_fire;
      if (rd_fire) begin
        rdata_o <= mem[idx] ^ flip_mask;
      end
    end
  end

  // Injection FSM: arming, one-shot consumption, corruption counter and handshakes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      bit0_q      <= '0;
      bit1_q      <= '0;
      inj_ack_o   <= 1'b0;
      inj_err_o   <= 1'b0;
      inj_armed_o <= 1'b0;
      inj_count_o <= '0;
    end else begin
      inj_ack_o <= inj_req_i & ~inj_bad;
      inj_err_o <= inj_req_i & inj_bad;

      if (rd_fire && (state != IDLE) && (inj_count_o != 16'hFFFF)) begin
        inj_count_o <= inj_count_o + 16'd1;
      end

      // An accepted request overrides whatever the concurrent read would have left.
      if (inj_req_i && !inj_bad) begin
        case (inj_mode_i)
          2'd0: begin
            state       <= ARMED_ONE;
            bit0_q      <= inj_bit0_i;
            inj_armed_o <= 1'b1;
          end
          2'd1: begin
            state       <= ARMED_TWO;
            bit0_q      <= inj_bit0_i;
            bit1_q      <= inj_bit1_i;
            inj_armed_o <= 1'b1;
          end
          2'd2: begin
            state       <= PERSIST;
            bit0_q      <= inj_bit0_i;
            inj_armed_o <= 1'b1;
          end
          default: begin
            state       <= IDLE;
            inj_armed_o <= 1'b0;
          end
        endcase
      end else if (rd_fire && ((state == ARMED_ONE) || (state == ARMED_TWO))) begin
        state       <= IDLE;
        inj_armed_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ibex_icache_sram_responder.sv
// Self-checking bench for ibex_icache_sram_responder: a transaction-level
// model (word array plus a pending flip mask) predicts every output each
// cycle, and literal expectations pin the model on the directed scenarios.
module tb_ibex_icache_sram_responder;

  localparam int DW    = 64;
  localparam int DEPTH = 256;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_i, write_i;
  logic [31:0]   addr_i;
  logic [DW-1:0] wdata_i, wmask_i, rdata_o;
  logic          rvalid_o;
  logic          inj_req_i;
  logic [1:0]    inj_mode_i;
  logic [7:0]    inj_bit0_i, inj_bit1_i;
  logic          inj_ack_o, inj_err_o, inj_armed_o;
  logic [15:0]   inj_count_o;

  always #5 clk_i = ~clk_i;

  ibex_icache_sram_responder #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .write_i    (write_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .wmask_i    (wmask_i),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .inj_req_i  (inj_req_i),
    .inj_mode_i (inj_mode_i),
    .inj_bit0_i (inj_bit0_i),
    .inj_bit1_i (inj_bit1_i),
    .inj_ack_o  (inj_ack_o),
    .inj_err_o  (inj_err_o),
    .inj_armed_o(inj_armed_o),
    .inj_count_o(inj_count_o)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: words, a mask of bits still to be flipped, and whether it is sticky.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] pend_mask;
  bit            sticky;
  int unsigned   m_cnt;
  logic [DW-1:0] exp_rdata;
  bit            exp_rvalid, exp_ack, exp_err;
  bit            rd_dc, rv_dc, chk_en;

  task automatic model_reset();
    pend_mask  = '0;
    sticky     = 1'b0;
    m_cnt      = 0;
    exp_rdata  = '0;
    exp_rvalid = 1'b0;
    exp_ack    = 1'b0;
    exp_err    = 1'b0;
    rd_dc      = 1'b0;
    rv_dc      = 1'b0;
  endtask

  task automatic model_edge(input logic req, input logic wr, input logic [31:0] addr,
                            input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                            input logic ir, input logic [1:0] md,
                            input logic [7:0] b0, input logic [7:0] b1);
    int  i;
    bit  bad;
    i          = int'(addr % DEPTH);
    exp_ack    = 1'b0;
    exp_err    = 1'b0;
    exp_rvalid = 1'b0;
    rv_dc      = 1'b0;
    if ((req === 1'bx) || ((req === 1'b1) && (wr === 1'bx))) begin
      rv_dc = 1'b1;
      rd_dc = 1'b1;
    end else if (req && !wr) begin
      exp_rvalid = 1'b1;
      exp_rdata  = m_mem[i] ^ pend_mask;
      rd_dc      = 1'b0;
      if (pend_mask != '0) begin
        if (m_cnt < 16'hFFFF) m_cnt++;
        if (!sticky) pend_mask = '0;
      end
    end else if (req && wr) begin
      m_mem[i] = (m_mem[i] & ~wm) | (wd & wm);
    end
    if (ir) begin
      bad = (int'(b0) >= DW) || ((md == 2'd1) && ((int'(b1) >= DW) || (b1 == b0)));
      if (bad) exp_err = 1'b1;
      else begin
        exp_ack = 1'b1;
        case (md)
          2'd0: begin pend_mask = 64'd1 << b0; sticky = 1'b0; end
          2'd1: begin pend_mask = (64'd1 << b0) | (64'd1 << b1); sticky = 1'b0; end
          2'd2: begin pend_mask = 64'd1 << b0; sticky = 1'b1; end
          default: begin pend_mask = '0; sticky = 1'b0; end
        endcase
      end
    end
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, then idle the inputs.
  task automatic step(input logic req, input logic wr, input logic [31:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                      input logic ir, input logic [1:0] md,
                      input logic [7:0] b0, input logic [7:0] b1);
    req_i = req; write_i = wr; addr_i = addr; wdata_i = wd; wmask_i = wm;
    inj_req_i = ir; inj_mode_i = md; inj_bit0_i = b0; inj_bit1_i = b1;
    @(posedge clk_i);
    model_edge(req, wr, addr, wd, wm, ir, md, b0, b1);
    #1;
    req_i = 1'b0; write_i = 1'b0; addr_i = '0; wdata_i = '0; wmask_i = '0;
    inj_req_i = 1'b0; inj_mode_i = '0; inj_bit0_i = '0; inj_bit1_i = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    step(1'b1, 1'b1, a, d, m, 1'b0, 2'd0, 8'd0, 8'd0);
  endtask
  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b0, a, '0, '0, 1'b0, 2'd0, 8'd0, 8'd0);
  endtask
  task automatic arm(input logic [1:0] md, input logic [7:0] b0, input logic [7:0] b1);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, md, b0, b1);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 2'd0, 8'd0, 8'd0);
  endtask

  // Compare process: every cycle out of reset, all outputs against the model.
  always @(negedge clk_i) begin
    if (chk_en && rst_ni) begin
      if (!rv_dc) check("rvalid", 64'(rvalid_o), 64'(exp_rvalid));
      if (!rd_dc) check("rdata", rdata_o, exp_rdata);
      check("ack", 64'(inj_ack_o), 64'(exp_ack));
      check("err", 64'(inj_err_o), 64'(exp_err));
      check("armed", 64'(inj_armed_o), 64'(pend_mask != '0));
      check("count", 64'(inj_count_o), 64'(m_cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [DW-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    rst_ni = 1'b0; chk_en = 1'b0;
    req_i = 1'b0; write_i = 1'b0; addr_i = '0; wdata_i = '0; wmask_i = '0;
    inj_req_i = 1'b0; inj_mode_i = '0; inj_bit0_i = '0; inj_bit1_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_armed", 64'(inj_armed_o), 64'd0);
    check("rst_count", 64'(inj_count_o), 64'd0);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // Masked write, latency and hold.
    wr(32'd5, 64'h0123_4567_89AB_CDEF, ONES);
    wr(32'd5, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_FFFF_0000_0000);
    rd(32'd5);
    check("masked_wr", rdata_o, 64'hFFFF_0000_89AB_CDEF);
    check("rvalid_lat", 64'(rvalid_o), 64'd1);
    idle();
    check("rvalid_drop", 64'(rvalid_o), 64'd0);
    check("rdata_hold", rdata_o, 64'hFFFF_0000_89AB_CDEF);

    // Index wrap-around.
    wr(32'h105, 64'hA5, ONES);
    rd(32'h5);
    check("wrap", rdata_o, 64'hA5);
    rd(32'hFFFF_FF05);
    check("wrap_hi", rdata_o, 64'hA5);

    // One-shot single flip.
    wr(32'd10, 64'd0, ONES);
    arm(2'd0, 8'd3, 8'd0);
    check("ack_one", 64'(inj_ack_o), 64'd1);
    rd(32'd10);
    check("one_first", rdata_o, 64'h8);
    check("one_disarm", 64'(inj_armed_o), 64'd0);
    rd(32'd10);
    check("one_second", rdata_o, 64'h0);
    check("one_count", 64'(inj_count_o), 64'd1);

    // Double flip, then rejected requests.
    arm(2'd1, 8'd0, 8'd63);
    rd(32'd10);
    check("double", rdata_o, 64'h8000_0000_0000_0001);
    arm(2'd1, 8'd4, 8'd4);
    check("dup_err", 64'(inj_err_o), 64'd1);
    check("dup_noack", 64'(inj_ack_o), 64'd0);
    arm(2'd0, 8'd64, 8'd0);
    check("range_err", 64'(inj_err_o), 64'd1);
    check("range_unarmed", 64'(inj_armed_o), 64'd0);

    // Persistent flip, then disarm.
    arm(2'd2, 8'd1, 8'd0);
    for (int k = 0; k < 3; k++) begin
      rd(32'd10);
      check("persist", rdata_o, 64'h2);
    end
    check("persist_count", 64'(inj_count_o), 64'd5);
    arm(2'd3, 8'd0, 8'd0);
    rd(32'd10);
    check("disarmed", rdata_o, 64'h0);

    // Same-cycle arm and read: old arming used, new one applies afterwards.
    arm(2'd0, 8'd5, 8'd0);
    step(1'b1, 1'b0, 32'd10, '0, '0, 1'b1, 2'd0, 8'd6, 8'd0);
    check("same_old", rdata_o, 64'h20);
    rd(32'd10);
    check("same_new", rdata_o, 64'h40);

    // Writes do not consume an armed one-shot.
    arm(2'd0, 8'd7, 8'd0);
    wr(32'd10, 64'd0, ONES);
    check("wr_keeps_arm", 64'(inj_armed_o), 64'd1);
    rd(32'd10);
    check("wr_noconsume", rdata_o, 64'h80);

    // Unknown strobe must not consume the injection.
    arm(2'd0, 8'd2, 8'd0);
    step(1'bx, 1'b0, 32'd10, '0, '0, 1'b0, 2'd0, 8'd0, 8'd0);
    idle();
    check("x_keeps_arm", 64'(inj_armed_o), 64'd1);
    rd(32'd10);
    check("x_then_read", rdata_o, 64'h4);
    check("count_9", 64'(inj_count_o), 64'd9);

    // Asynchronous reset while armed; memory retained.
    arm(2'd0, 8'd3, 8'd0);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_rdata", rdata_o, 64'd0);
    check("mid_rst_armed", 64'(inj_armed_o), 64'd0);
    check("mid_rst_count", 64'(inj_count_o), 64'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    check("rst_hold_rdata", rdata_o, 64'd0);
    rst_ni = 1'b1;
    rd(32'd5);
    check("post_rst_data", rdata_o, 64'hA5);
    check("post_rst_count", 64'(inj_count_o), 64'd0);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
